char_writer: RTL and testbench
==============================

// Module: char_writer
// PURPOSE
//   Write-side controller for the 80x25 character buffer RAM. Consumes a byte stream
//   (valid/ready) from the terminal input path, tracks the cursor, and drives the buffer
//   write port (waddr/din/write_en). Scrolls by rotating a first_row pointer, which the
//   video reader uses, and blanks the newly exposed bottom line.
//   Also blanks the whole screen after reset and on request.
// PARAMETERS
//   COLS       80     characters per row
//   ROWS       25     rows per screen; BUF_SIZE = COLS*ROWS
//   ADDR_BITS  11     buffer address width; must satisfy 2**ADDR_BITS >= COLS*ROWS
//   FILL_CHAR  8'h20  byte written by clear and scroll fills
// PORTS
//   clk          in   1          single clock; all logic is posedge clk
//   reset        in   1          synchronous, active-high reset
//   char_in      in   8          input byte
//   char_valid   in   1          char_in is valid
//   char_ready   out  1          combinational: (state==IDLE) && !clear_req
//   clear_req    in   1          request a full-screen clear (sampled in IDLE only)
//   waddr        out  ADDR_BITS  buffer write address (registered)
//   din          out  8          buffer write data (registered)
//   write_en     out  1          buffer write strobe (registered, 1 cycle per write)
//   cursor_x     out  7          cursor column, 0..COLS-1
//   cursor_y     out  5          cursor row on screen, 0..ROWS-1 (logical, not physical)
//   first_row    out  5          physical buffer row displayed as screen row 0
//   busy         out  1          high in CLEAR or SCROLL_FILL
// BEHAVIOUR
//   Reset: write_en=0, waddr=0, din=0, cursor_x=0, cursor_y=0, first_row=0, fill count=0;
//     state=CLEAR. Reset in any state aborts the current operation and restarts CLEAR.
//   Address: phys_row = first_row+row, minus ROWS if >= ROWS. addr = phys_row*COLS+col.
//   States:
//   CLEAR: one write per cycle of FILL_CHAR to addr 0..COLS*ROWS-1 ascending (2000 cycles
//     at default). The first write_en is in the cycle after reset deasserts. Cursor and
//     first_row are held at 0. Then go to IDLE. char_ready=0 throughout.
//   IDLE: clear_req=1 -> cursor=(0,0), first_row=0, go to CLEAR; same-cycle char_valid
//     is not accepted. Otherwise a byte is accepted when char_valid && char_ready:
//     0x20..0x7E: next cycle write_en=1, waddr=addr(cursor_y,cursor_x), din=byte. Then
//       cursor_x+1; at cursor_x==COLS-1 wrap cursor_x=0 and do NEWLINE.
//     0x0A (LF): NEWLINE.  0x0D (CR): cursor_x=0.  0x08 (BS): cursor_x-1 if >0, else hold.
//     Any other byte: consumed, no write, no cursor change.
//   NEWLINE: if cursor_y<ROWS-1 -> cursor_y+1. Else scroll: first_row<=first_row+1 mod ROWS,
//     cursor_y stays ROWS-1. The old first_row becomes the new bottom physical row.
//     Go to SCROLL_FILL.
//   SCROLL_FILL: COLS consecutive writes of FILL_CHAR to physical row (old first_row),
//     cols 0..COLS-1, one per cycle. The first fill write is in the cycle after the write
//     for the accepted byte, if there is one. The fill never overlaps that write.
//     Then go to IDLE. char_ready=0 throughout.
//   write_en pulses exactly once per write. There are no writes while IDLE and no byte
//     is pending.
//   Latency: accept -> write_en is 1 cycle. Back-to-back accepts in IDLE give 1 write/cycle.
//   Wrap at the last column of the last row: the char is written to (ROWS-1,COLS-1),
//     then scroll, and the cursor ends at (ROWS-1,0).
// TESTING
//   T1 reset then release: write_en exactly 2000 cycles, waddr 0..1999, din=0x20;
//      then char_ready=1 and cursor=(0,0).
//   T2 send 'A','B' back-to-back at (0,0): writes addr0=0x41, addr1=0x42 on consecutive
//      cycles; cursor_x=2.
//   T3 send 80 x 'x' from (0,0): last write at addr 79; cursor=(1,0); no scroll, first_row=0.
//   T4 cursor at (24,5), send LF: first_row=1, cursor=(24,5); 80 writes of 0x20 to
//      addr 0..79; char_ready=0 for those 80 cycles. Then send 'Z': write to addr 5.
//   T5 CR, BS at x=0 (hold), BS at x=3 (->2), byte 0x07: no writes, cursor updates only.
//   T6 clear_req with char_valid in the same cycle: char not accepted; 2000-write clear;
//      first_row=0. Reset asserted mid-scroll: restarts clear from addr 0.

Source files
------------

// File: rtl/char_writer.sv
// Write-side controller for the character buffer: cursor tracking, buffer writes,
// scroll by first_row rotation with bottom-line blanking, and full-screen clear.
module char_writer #(
   parameter int unsigned COLS      = 80,
   parameter int unsigned ROWS      = 25,
   parameter int unsigned ADDR_BITS = 11,
   parameter logic [7:0]  FILL_CHAR = 8'h20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           char_in,
   input  logic                 char_valid,
   output logic                 char_ready,
   input  logic                 clear_req,
   output logic [ADDR_BITS-1:0] waddr,
   output logic [7:0]           din,
   output logic                 write_en,
   output logic [6:0]           cursor_x,
   output logic [4:0]           cursor_y,
   output logic [4:0]           first_row,
   output logic                 busy
);

   localparam logic [ADDR_BITS-1:0] COLS_A    = ADDR_BITS'(COLS);
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(COLS * ROWS - 1);
   localparam logic [ADDR_BITS-1:0] LAST_FILL = ADDR_BITS'(COLS - 1);
   localparam logic [6:0]           LAST_COL  = 7'(COLS - 1);
   localparam logic [4:0]           LAST_ROW  = 5'(ROWS - 1);
   localparam logic [5:0]           ROWS_6    = 6'(ROWS);

   typedef enum logic [1:0] {StClear, StIdle, StScrollFill} state_e;

   state_e                 r_state, w_state_nxt;
   logic [ADDR_BITS-1:0]   r_waddr, w_waddr_nxt;
   logic [7:0]             r_din, w_din_nxt;
   logic                   r_we, w_we_nxt;
   logic [6:0]             r_cx, w_cx_nxt;
   logic [4:0]             r_cy, w_cy_nxt;
   logic [4:0]             r_fr, w_fr_nxt;
   logic [ADDR_BITS-1:0]   r_fill_cnt, w_fill_cnt_nxt;
   logic [4:0]             r_fill_row, w_fill_row_nxt;

   logic                   w_accept;
   logic                   w_printable;
   logic                   w_newline;
   logic                   w_scroll;
   logic [5:0]             w_phys_sum;
   logic [5:0]             w_phys_row;
   logic [ADDR_BITS-1:0]   w_cur_addr;
   logic [ADDR_BITS-1:0]   w_fill_addr;

   // Logical cursor row maps to a physical buffer row through the rotating first_row.
   assign w_phys_sum  = {1'b0, r_fr} + {1'b0, r_cy};
   assign w_phys_row  = (w_phys_sum >= ROWS_6) ? (w_phys_sum - ROWS_6) : w_phys_sum;
   assign w_cur_addr  = ADDR_BITS'(w_phys_row) * COLS_A + ADDR_BITS'(r_cx);
   assign w_fill_addr = ADDR_BITS'(r_fill_row) * COLS_A + r_fill_cnt;
   assign w_accept    = char_valid && char_ready;
   assign w_printable = (char_in >= 8'h20) && (char_in <= 8'h7E);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StClear;
         r_waddr    <= '0;
         r_din      <= '0;
         r_we       <= 1'b0;
         r_cx       <= '0;
         r_cy       <= '0;
         r_fr       <= '0;
         r_fill_cnt <= '0;
         r_fill_row <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_waddr    <= w_waddr_nxt;
         r_din      <= w_din_nxt;
         r_we       <= w_we_nxt;
         r_cx       <= w_cx_nxt;
         r_cy       <= w_cy_nxt;
         r_fr       <= w_fr_nxt;
         r_fill_cnt <= w_fill_cnt_nxt;
         r_fill_row <= w_fill_row_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StClear:      if (r_fill_cnt == LAST_ADDR) w_state_nxt = StIdle;
         StIdle: begin
            if (clear_req)     w_state_nxt = StClear;
            else if (w_scroll) w_state_nxt = StScrollFill;
         end
         StScrollFill: if (r_fill_cnt == LAST_FILL) w_state_nxt = StIdle;
         default:      w_state_nxt = StClear;
      endcase
   end

   always_comb begin
      w_waddr_nxt    = r_waddr;
      w_din_nxt      = r_din;
      w_we_nxt       = 1'b0;
      w_cx_nxt       = r_cx;
      w_cy_nxt       = r_cy;
      w_fr_nxt       = r_fr;
      w_fill_cnt_nxt = r_fill_cnt;
      w_fill_row_nxt = r_fill_row;
      w_newline      = 1'b0;
      w_scroll       = 1'b0;
      unique case (r_state)
         StClear: begin
            w_we_nxt       = 1'b1;
            w_waddr_nxt    = r_fill_cnt;
            w_din_nxt      = FILL_CHAR;
            w_fill_cnt_nxt = (r_fill_cnt == LAST_ADDR) ? '0 : r_fill_cnt + 1'b1;
            w_cx_nxt       = '0;
            w_cy_nxt       = '0;
            w_fr_nxt       = '0;
         end
         StIdle: begin
            if (clear_req) begin
               w_cx_nxt       = '0;
               w_cy_nxt       = '0;
               w_fr_nxt       = '0;
               w_fill_cnt_nxt = '0;
            end else if (w_accept) begin
               if (w_printable) begin
                  w_we_nxt    = 1'b1;
                  w_waddr_nxt = w_cur_addr;
                  w_din_nxt   = char_in;
                  if (r_cx == LAST_COL) begin
                     w_cx_nxt  = '0;
                     w_newline = 1'b1;
                  end else begin
                     w_cx_nxt = r_cx + 1'b1;
                  end
               end else if (char_in == 8'h0A) begin
                  w_newline = 1'b1;
               end else if (char_in == 8'h0D) begin
                  w_cx_nxt = '0;
               end else if (char_in == 8'h08) begin
                  if (r_cx != '0) w_cx_nxt = r_cx - 1'b1;
               end
               if (w_newline) begin
                  if (r_cy != LAST_ROW) begin
                     w_cy_nxt = r_cy + 1'b1;
                  end else begin
                     // Old top row becomes the new bottom row and is blanked.
                     w_scroll       = 1'b1;
                     w_fr_nxt       = (r_fr == LAST_ROW) ? '0 : r_fr + 1'b1;
                     w_fill_row_nxt = r_fr;
                     w_fill_cnt_nxt = '0;
                  end
               end
            end
         end
         StScrollFill: begin
            w_we_nxt       = 1'b1;
            w_waddr_nxt    = w_fill_addr;
            w_din_nxt      = FILL_CHAR;
            w_fill_cnt_nxt = (r_fill_cnt == LAST_FILL) ? '0 : r_fill_cnt + 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      char_ready = (r_state == StIdle) && !clear_req;
      busy       = (r_state == StClear) || (r_state == StScrollFill);
      waddr      = r_waddr;
      din        = r_din;
      write_en   = r_we;
      cursor_x   = r_cx;
      cursor_y   = r_cy;
      first_row  = r_fr;
   end

endmodule

// File: tb/tb_char_writer.sv
// Scoreboard bench for char_writer: a cursor/scroll model predicts every buffer write.
module tb_char_writer;

   logic        clk;
   logic        reset;
   logic [7:0]  char_in;
   logic        char_valid;
   logic        char_ready;
   logic        clear_req;
   logic [10:0] waddr;
   logic [7:0]  din;
   logic        write_en;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic [4:0]  first_row;
   logic        busy;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [18:0] exp_q[$];
   int          m_x, m_y, m_first;

   char_writer dut (
      .clk       (clk),
      .reset     (reset),
      .char_in   (char_in),
      .char_valid(char_valid),
      .char_ready(char_ready),
      .clear_req (clear_req),
      .waddr     (waddr),
      .din       (din),
      .write_en  (write_en),
      .cursor_x  (cursor_x),
      .cursor_y  (cursor_y),
      .first_row (first_row),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset !== 1'b1 && write_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_write", {21'd0, waddr}, 32'hFFFF_FFFF);
         end else begin
            logic [18:0] e;
            e = exp_q.pop_front();
            chk("waddr", {21'd0, waddr}, {21'd0, e[18:8]});
            chk("din", {24'd0, din}, {24'd0, e[7:0]});
         end
      end
   end

   function automatic logic [10:0] f_addr(int fr, int y, int x);
      return 11'(((fr + y) % 25) * 80 + x);
   endfunction

   task automatic push_clear();
      for (int i = 0; i < 2000; i++) exp_q.push_back({11'(i), 8'h20});
      m_x = 0; m_y = 0; m_first = 0;
   endtask

   task automatic m_newline();
      if (m_y < 24) begin
         m_y++;
      end else begin
         for (int c = 0; c < 80; c++) exp_q.push_back({11'(m_first * 80 + c), 8'h20});
         m_first = (m_first + 1) % 25;
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      while (char_ready !== 1'b1 && n < 5000) begin
         @(posedge clk); #1; n++;
      end
      if (char_ready !== 1'b1) begin
         chk("ready_timeout", 32'd0, 32'd1);
         return;
      end
      char_in    = b;
      char_valid = 1'b1;
      if (b >= 8'h20 && b <= 8'h7E) begin
         exp_q.push_back({f_addr(m_first, m_y, m_x), b});
         if (m_x == 79) begin
            m_x = 0;
            m_newline();
         end else begin
            m_x++;
         end
      end else if (b == 8'h0A) begin
         m_newline();
      end else if (b == 8'h0D) begin
         m_x = 0;
      end else if (b == 8'h08) begin
         if (m_x > 0) m_x--;
      end
      @(posedge clk); #1;
      char_valid = 1'b0;
      if (b >= 8'h20 && b <= 8'h7E) chk("accept_latency", {31'd0, write_en}, 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!(char_ready === 1'b1 && exp_q.size() == 0) && n < 5000);
      chk("idle_reached", {31'd0, (char_ready === 1'b1 && exp_q.size() == 0)}, 32'd1);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_cx"}, {25'd0, cursor_x}, 32'(m_x));
      chk({tag, "_cy"}, {27'd0, cursor_y}, 32'(m_y));
      chk({tag, "_fr"}, {27'd0, first_row}, 32'(m_first));
   endtask

   initial begin
      reset      = 1'b1;
      char_valid = 1'b0;
      char_in    = 8'h00;
      clear_req  = 1'b0;
      m_x = 0; m_y = 0; m_first = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we", {31'd0, write_en}, 32'd0);
      chk("rst_waddr", {21'd0, waddr}, 32'd0);
      chk("rst_din", {24'd0, din}, 32'd0);
      chk("rst_ready", {31'd0, char_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      check_state("rst");

      // T1: power-up clear
      reset = 1'b0;
      push_clear();
      wait_idle();
      check_state("t1");

      // T2: back-to-back printable bytes
      send(8'h41);
      send(8'h42);
      wait_idle();
      check_state("t2");
      chk("t2_x", {25'd0, cursor_x}, 32'd2);

      // T3: full row wraps to the next line without scrolling
      send(8'h0D);
      for (int i = 0; i < 80; i++) send(8'h78);
      wait_idle();
      check_state("t3");
      chk("t3_y", {27'd0, cursor_y}, 32'd1);

      // T5: control bytes move the cursor only
      send(8'h0D);
      send(8'h08);
      send(8'h61);
      send(8'h62);
      send(8'h63);
      send(8'h08);
      send(8'h07);
      wait_idle();
      check_state("t5");
      chk("t5_x", {25'd0, cursor_x}, 32'd2);

      // T4: LF on the last row scrolls and blanks the old top row
      for (int i = 0; i < 23; i++) send(8'h0A);
      send(8'h0D);
      for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
      wait_idle();
      check_state("t4_pre");
      send(8'h0A);
      for (int i = 0; i < 80; i++) begin
         chk("fill_ready", {31'd0, char_ready}, 32'd0);
         @(posedge clk); #1;
      end
      wait_idle();
      check_state("t4");
      chk("t4_fr", {27'd0, first_row}, 32'd1);
      send(8'h5A);
      wait_idle();

      // Wrap at the last column of the last row
      for (int i = 0; i < 73; i++) send(8'h77);
      send(8'h45);
      wait_idle();
      check_state("wrap");
      chk("wrap_x", {25'd0, cursor_x}, 32'd0);

      // T6: clear_req wins over a same-cycle byte
      clear_req  = 1'b1;
      char_valid = 1'b1;
      char_in    = 8'h51;
      #1;
      chk("clr_ready", {31'd0, char_ready}, 32'd0);
      push_clear();
      @(posedge clk); #1;
      clear_req  = 1'b0;
      char_valid = 1'b0;
      chk("clr_busy", {31'd0, busy}, 32'd1);
      wait_idle();
      check_state("t6");

      // Reset in the middle of a scroll fill restarts the clear
      for (int i = 0; i < 25; i++) send(8'h0A);
      repeat (10) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      chk("mid_rst_we", {31'd0, write_en}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      push_clear();
      wait_idle();
      check_state("t6_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
